// File: rtl/cnn_pkg.sv
// cnn_pkg: shared sequencer state codes and buffer address-width helper.
package cnn_pkg;

    localparam int STAGE_W = 3;

    typedef enum logic [STAGE_W-1:0] {
        S_IDLE   = 3'd0,
        S_CONV   = 3'd1,
        S_RELU   = 3'd2,
        S_POOL   = 3'd3,
        S_DENSE  = 3'd4,
        S_FINISH = 3'd5,
        S_ERROR  = 3'd6
    } seq_state_t;

    function automatic int calc_aw(input int ch, input int sz);
        return $clog2(ch * sz * sz);
    endfunction

endpackage

// File: rtl/cnn_sequencer_if.sv
// cnn_seq_if: run control, per-stage handshakes, conv-buffer ports and requester bundles.
interface cnn_seq_if
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 8,
    parameter int IMG_SIZE   = 28,
    parameter int AW         = calc_aw(CHANNELS, IMG_SIZE)
);
    logic                         start, done, busy, err;
    logic [STAGE_W-1:0]           stage;
    logic                         conv_start, relu_start, pool_start, dense_start;
    logic                         conv_done, relu_done, pool_done, dense_done;
    logic [AW-1:0]                buf_r_addr, buf_w_addr;
    logic                         buf_r_en, buf_w_en, buf_w_we;
    logic signed [DATA_WIDTH-1:0] buf_w_d;
    logic [AW-1:0]                conv_w_addr, relu_r_addr, relu_w_addr, pool_r_addr;
    logic                         conv_w_en, conv_w_we, relu_r_en, relu_w_en, relu_w_we, pool_r_en;
    logic signed [DATA_WIDTH-1:0] conv_w_d, relu_w_d;

    modport slave (
        input  start, conv_done, relu_done, pool_done, dense_done,
               conv_w_addr, conv_w_en, conv_w_we, conv_w_d,
               relu_r_addr, relu_r_en, relu_w_addr, relu_w_en, relu_w_we, relu_w_d,
               pool_r_addr, pool_r_en,
        output done, busy, err, stage, conv_start, relu_start, pool_start, dense_start,
               buf_r_addr, buf_r_en, buf_w_addr, buf_w_en, buf_w_we, buf_w_d
    );

    modport master (
        output start, conv_done, relu_done, pool_done, dense_done,
               conv_w_addr, conv_w_en, conv_w_we, conv_w_d,
               relu_r_addr, relu_r_en, relu_w_addr, relu_w_en, relu_w_we, relu_w_d,
               pool_r_addr, pool_r_en,
        input  done, busy, err, stage, conv_start, relu_start, pool_start, dense_start,
               buf_r_addr, buf_r_en, buf_w_addr, buf_w_en, buf_w_we, buf_w_d
    );

endinterface

// File: rtl/cnn_sequencer_buf_port_mux.sv
// buf_port_mux: grants the conv-buffer read/write ports to the requester owned by the current state.
module buf_port_mux
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int AW         = 13
) (
    input  seq_state_t                   state_i,
    input  logic [AW-1:0]                conv_w_addr_i,
    input  logic                         conv_w_en_i,
    input  logic                         conv_w_we_i,
    input  logic signed [DATA_WIDTH-1:0] conv_w_d_i,
    input  logic [AW-1:0]                relu_r_addr_i,
    input  logic                         relu_r_en_i,
    input  logic [AW-1:0]                relu_w_addr_i,
    input  logic                         relu_w_en_i,
    input  logic                         relu_w_we_i,
    input  logic signed [DATA_WIDTH-1:0] relu_w_d_i,
    input  logic [AW-1:0]                pool_r_addr_i,
    input  logic                         pool_r_en_i,
    output logic [AW-1:0]                buf_r_addr_o,
    output logic                         buf_r_en_o,
    output logic [AW-1:0]                buf_w_addr_o,
    output logic                         buf_w_en_o,
    output logic                         buf_w_we_o,
    output logic signed [DATA_WIDTH-1:0] buf_w_d_o
);
    logic conv, relu, pool;

    assign conv = state_i == S_CONV;
    assign relu = state_i == S_RELU;
    assign pool = state_i == S_POOL;

    always_comb begin
        buf_r_addr_o = relu ? relu_r_addr_i : pool ? pool_r_addr_i : '0;
        buf_r_en_o   = relu ? relu_r_en_i   : pool ? pool_r_en_i   : 1'b0;
        buf_w_addr_o = conv ? conv_w_addr_i : relu ? relu_w_addr_i : '0;
        buf_w_en_o   = conv ? conv_w_en_i   : relu ? relu_w_en_i   : 1'b0;
        buf_w_we_o   = conv ? conv_w_we_i   : relu ? relu_w_we_i   : 1'b0;
        buf_w_d_o    = conv ? conv_w_d_i    : relu ? relu_w_d_i    : '0;
    end

endmodule

// File: rtl/cnn_sequencer.sv
// cnn_sequencer: CONV->RELU->POOL->DENSE run sequencer with conv-buffer port routing.
// Define CNN_SEQ_WATCHDOG_EN to add the per-stage TIMEOUT watchdog and ERROR state.
module cnn_sequencer
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 8,
    parameter int IMG_SIZE   = 28,
    parameter int TIMEOUT    = 65535
) (
    input logic      clk,
    input logic      reset_n,
    cnn_seq_if.slave bus
);
    localparam int AW = calc_aw(CHANNELS, IMG_SIZE);

    seq_state_t state_q, state_d;
    logic       entry_q, in_stage, stg_done, timeout;

    assign in_stage = state_q inside {[S_CONV:S_DENSE]};

    // a stage's done is only honoured after its start cycle
    assign stg_done = !entry_q && ((state_q == S_CONV  && bus.conv_done)
                                || (state_q == S_RELU  && bus.relu_done)
                                || (state_q == S_POOL  && bus.pool_done)
                                || (state_q == S_DENSE && bus.dense_done));

`ifdef CNN_SEQ_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    assign timeout = in_stage && !stg_done && cnt_q == CW'(TIMEOUT - 1);
    assign cnt_d   = (in_stage && state_d == state_q) ? cnt_q + CW'(1) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign bus.err = state_q == S_ERROR;
`else
    assign timeout = 1'b0;
    assign bus.err = TIMEOUT < 0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ERROR: state_d = bus.start ? S_CONV : state_q;
            S_FINISH:        state_d = S_IDLE;
            default:         state_d = stg_done ? seq_state_t'(state_q + 3'd1) : timeout ? S_ERROR : state_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            entry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= state_d != state_q;
        end
    end

    assign bus.stage       = state_q;
    assign bus.busy        = state_q inside {[S_CONV:S_FINISH]};
    assign bus.done        = state_q == S_FINISH;
    assign bus.conv_start  = entry_q && state_q == S_CONV;
    assign bus.relu_start  = entry_q && state_q == S_RELU;
    assign bus.pool_start  = entry_q && state_q == S_POOL;
    assign bus.dense_start = entry_q && state_q == S_DENSE;

    buf_port_mux #(.DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_mux (
        .state_i       (state_q),
        .conv_w_addr_i (bus.conv_w_addr),
        .conv_w_en_i   (bus.conv_w_en),
        .conv_w_we_i   (bus.conv_w_we),
        .conv_w_d_i    (bus.conv_w_d),
        .relu_r_addr_i (bus.relu_r_addr),
        .relu_r_en_i   (bus.relu_r_en),
        .relu_w_addr_i (bus.relu_w_addr),
        .relu_w_en_i   (bus.relu_w_en),
        .relu_w_we_i   (bus.relu_w_we),
        .relu_w_d_i    (bus.relu_w_d),
        .pool_r_addr_i (bus.pool_r_addr),
        .pool_r_en_i   (bus.pool_r_en),
        .buf_r_addr_o  (bus.buf_r_addr),
        .buf_r_en_o    (bus.buf_r_en),
        .buf_w_addr_o  (bus.buf_w_addr),
        .buf_w_en_o    (bus.buf_w_en),
        .buf_w_we_o    (bus.buf_w_we),
        .buf_w_d_o     (bus.buf_w_d)
    );

endmodule

// File: tb/tb_cnn_sequencer.sv
// tb_cnn_sequencer: scoreboarded stage-pulse timing, routing vector table and reset/watchdog corner cases.
module tb_cnn_sequencer;
    import cnn_pkg::*;

`ifdef CNN_SEQ_WATCHDOG_EN
    localparam int TO = 20;
`else
    localparam int TO = 65535;
`endif
    localparam int AW = calc_aw(8, 28);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cnn_seq_if bus ();

    cnn_sequencer #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        int id;
        int cyc;
    } ev_t;

    typedef struct {
        logic [2:0] stg;
        int cwa, cwd, rra, rwa, rwd, pra;
        int era, eren, ewa, ewen, ewd;
    } rv_t;

    ev_t sb[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    bit  run_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ids: 0 conv_start, 1 relu_start, 2 pool_start, 3 dense_start, 4 done
    always @(negedge clk) begin
        logic [4:0] ev;
        ev = {bus.done, bus.dense_start, bus.pool_start, bus.relu_start, bus.conv_start};
        for (int k = 0; k < 5; k++) begin
            if (ev[k]) begin
                if (sb.size() == 0) chk($sformatf("unexpected_pulse_%0d", k), cyc, -1);
                else begin
                    ev_t e;
                    e = sb.pop_front();
                    chk("pulse_id", k, e.id);
                    chk("pulse_cycle", cyc, e.cyc);
                end
            end
        end
        if (run_chk && cyc >= 10 && cyc <= 36) chk("busy_run", bus.busy, (cyc >= 11 && cyc <= 35) ? 1 : 0);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_done(input int k, input logic v);
        bus.conv_done  = (k == 0) ? v : 1'b0;
        bus.relu_done  = (k == 1) ? v : 1'b0;
        bus.pool_done  = (k == 2) ? v : 1'b0;
        bus.dense_done = (k == 3) ? v : 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        sb.push_back('{0, cyc + 1});
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic pulse_done(input int k);
        set_done(k, 1'b1);
        sb.push_back('{k + 1, cyc + 1});
        step(1);
        set_done(k, 1'b0);
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        sb.delete();
    endtask

    // returns in the first cycle of the requested state
    task automatic goto(input int stg);
        reset_pulse();
        step(1);
        if (stg == 0) return;
        pulse_start();
        for (int k = 0; k < stg - 1; k++) begin
            step(1);
            pulse_done(k);
        end
    endtask

    task automatic drive_req(input rv_t t);
        bus.conv_w_addr = AW'(t.cwa);
        bus.conv_w_d    = 16'(t.cwd);
        bus.relu_r_addr = AW'(t.rra);
        bus.relu_w_addr = AW'(t.rwa);
        bus.relu_w_d    = 16'(t.rwd);
        bus.pool_r_addr = AW'(t.pra);
        {bus.conv_w_en, bus.conv_w_we, bus.relu_r_en, bus.relu_w_en, bus.relu_w_we, bus.pool_r_en} = '1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        rv_t tv[5];
        int t;
        tv[0] = '{3'd1, 10, 7, 20, 30, -3, 40,   0, 0, 10, 1, 7};
        tv[1] = '{3'd2, 11, 8, 100, 99, -5, 41,  100, 1, 99, 1, -5};
        tv[2] = '{3'd3, 12, 9, 21, 31, -4, 42,   42, 1, 0, 0, 0};
        tv[3] = '{3'd4, 13, 6, 22, 32, -6, 43,   0, 0, 0, 0, 0};
        tv[4] = '{3'd0, 14, 5, 23, 33, -7, 44,   0, 0, 0, 0, 0};

        bus.start = 1'b0;
        set_done(0, 1'b0);
        {bus.conv_w_en, bus.conv_w_we, bus.relu_r_en, bus.relu_w_en, bus.relu_w_we, bus.pool_r_en} = '0;
        bus.conv_w_addr = '0; bus.relu_r_addr = '0; bus.relu_w_addr = '0; bus.pool_r_addr = '0;
        bus.conv_w_d = '0; bus.relu_w_d = '0;

        #1;
        chk("rst_stage", bus.stage, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_conv_start", bus.conv_start, 0);
        chk("rst_buf_en", {bus.buf_r_en, bus.buf_w_en, bus.buf_w_we}, 0);
        #1 reset_n = 1'b1;

        // full run: start in cycle 10, each stage done 5 cycles after its start
        run_chk = 1'b1;
        wait_to(10);
        pulse_start();
        wait_to(16);
        chk("run_stage_conv", bus.stage, 1);
        pulse_done(0);
        wait_to(22);
        chk("run_stage_relu", bus.stage, 2);
        pulse_done(1);
        wait_to(28);
        chk("run_stage_pool", bus.stage, 3);
        pulse_done(2);
        wait_to(34);
        chk("run_stage_dense", bus.stage, 4);
        pulse_done(3);
        wait_to(35);
        chk("run_stage_finish", bus.stage, 5);
        wait_to(37);
        run_chk = 1'b0;
        chk("run_stage_idle", bus.stage, 0);
        chk("run_sb_drained", sb.size(), 0);

        // stray handshakes and done during a start cycle
        reset_pulse();
        step(1);
        pulse_start();
        bus.conv_done = 1'b1;
        step(1);
        bus.conv_done = 1'b0;
        chk("stray_entry_done", bus.stage, 1);
        bus.pool_done = 1'b1;
        step(1);
        bus.pool_done = 1'b0;
        chk("stray_pool_done", bus.stage, 1);
        pulse_done(0);
        bus.start = 1'b1;
        step(2);
        bus.start = 1'b0;
        chk("stray_start_relu", bus.stage, 2);
        step(2);
        chk("stray_sb_drained", sb.size(), 0);

        // routing vectors
        for (int i = 0; i < 5; i++) begin
            drive_req(tv[i]);
            goto(int'(tv[i].stg));
            #1;
            chk($sformatf("route%0d_stage", i), bus.stage, tv[i].stg);
            chk($sformatf("route%0d_r_addr", i), bus.buf_r_addr, tv[i].era);
            chk($sformatf("route%0d_r_en", i), bus.buf_r_en, tv[i].eren);
            chk($sformatf("route%0d_w_addr", i), bus.buf_w_addr, tv[i].ewa);
            chk($sformatf("route%0d_w_en", i), bus.buf_w_en, tv[i].ewen);
            chk($sformatf("route%0d_w_we", i), bus.buf_w_we, tv[i].ewen);
            chk($sformatf("route%0d_w_d", i), bus.buf_w_d, tv[i].ewd);
        end
        step(1);
        chk("route_sb_drained", sb.size(), 0);

        // asynchronous reset in the first cycle of POOL
        drive_req(tv[2]);
        goto(3);
        chk("pool_pre_start", bus.pool_start, 1);
        chk("pool_pre_r_en", bus.buf_r_en, 1);
        reset_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_stage", bus.stage, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_err", bus.err, 0);
        chk("arst_pool_start", bus.pool_start, 0);
        chk("arst_buf_en", {bus.buf_r_en, bus.buf_w_en, bus.buf_w_we}, 0);
        reset_n = 1'b1;
        step(1);
        pulse_start();
        chk("arst_restart_stage", bus.stage, 1);
        step(3);
        chk("arst_sb_drained", sb.size(), 0);

`ifdef CNN_SEQ_WATCHDOG_EN
        goto(2);
        t = cyc;
        wait_to(t + 19);
        chk("wd_err_before", bus.err, 0);
        chk("wd_stage_before", bus.stage, 2);
        wait_to(t + 20);
        chk("wd_err", bus.err, 1);
        chk("wd_stage_error", bus.stage, 6);
        chk("wd_busy", bus.busy, 0);
        chk("wd_done", bus.done, 0);
        step(5);
        chk("wd_err_sticky", bus.err, 1);
        pulse_start();
        chk("wd_err_cleared", bus.err, 0);
        chk("wd_restart_stage", bus.stage, 1);
`else
        goto(2);
        t = cyc;
        wait_to(t + 1000);
        chk("nowd_err", bus.err, 0);
        chk("nowd_stage", bus.stage, 2);
        chk("nowd_busy", bus.busy, 1);
`endif
        step(3);
        chk("final_sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
